// File: rtl/instr_fetch.sv
// Instruction fetch: registered imem read feeding a small valid/ready FIFO.
// pc_stall throttles the PC so the buffer never overflows.
module instr_fetch #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_val,
    input  logic              fetch_en,
    output logic              pc_stall,
    input  logic              flush,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [DATA_W-1:0] imem_wdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [BUF_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q [BUF_DEPTH];

    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_pc_q, s1_pc_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic             acc;
    logic             pop;
    logic             push;
    logic [CNT_W:0]   occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign instr_valid = (count_q != '0);
    assign instr_data  = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;

    always_comb begin
        pop  = instr_valid & instr_ready;
        // Occupancy after this edge if nothing new is accepted.
        occ  = (CNT_W+1)'(count_q) + (CNT_W+1)'(s1_valid_q)
             - (CNT_W+1)'(pop);
        pc_stall = ~flush & (occ >= (CNT_W+1)'(BUF_DEPTH));
        acc  = fetch_en & ~pc_stall & ~flush;
        push = s1_valid_q & ~flush;

        s1_valid_d = acc;
        s1_pc_d    = acc ? pc_val : s1_pc_q;
        s1_data_d  = acc ? mem[pc_val] : s1_data_q;

        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_data_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pc_q    <= s1_pc_d;
            s1_data_q  <= s1_data_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage arrays carry no reset; occupancy alone qualifies them.
    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
        if (push && !rst) begin
            fifo_data_q[wr_ptr_q] <= s1_data_q;
            fifo_pc_q[wr_ptr_q]   <= s1_pc_q;
        end
    end

endmodule
